// File: rtl/csr_bank_ch_if.sv
// Host-side register bus for csr_bank_ch: per-channel write strobes plus a registered read port.
interface csr_bank_ch_if #(
  parameter int CHANNELS = 4,
  parameter int CFG_W    = 8
);
  localparam int REG_W = CFG_W + 5;
  localparam int SEL_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic [CHANNELS-1:0] wr_en;
  logic [REG_W-1:0]    wr_data;
  logic                rd_en;
  logic [SEL_W-1:0]    rd_sel;
  logic [REG_W-1:0]    rd_data;
  logic                rd_valid;

  modport master (output wr_en, wr_data, rd_en, rd_sel, input rd_data, rd_valid);
  modport slave  (input wr_en, wr_data, rd_en, rd_sel, output rd_data, rd_valid);
endinterface

// File: rtl/csr_bank_ch.sv
// Multi-channel engine CSR bank: start/busy/done/error/ie/cfg per channel, busy watchdog,
// registered host read port and a combined registered interrupt.
module csr_bank_ch_lane #(
    parameter int CFG_W   = 8,
    parameter int TIMEOUT = 1024
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             wrEn,
    input  logic [CFG_W+4:0] wrData,
    input  logic             hwDone,
    input  logic             hwError,
    output logic             hwStart,
    output logic             hwAbort,
    output logic [CFG_W+4:0] regVal
);
    localparam int CNT_W = $clog2(TIMEOUT);

    logic             busy, done, err, ie;
    logic [CFG_W-1:0] cfgQ;
    logic [CNT_W-1:0] cnt;
    logic             startReq, accept, finish, wdFire;

    assign startReq = wrEn & wrData[0];
    assign accept   = startReq & ~busy;
    assign finish   = busy & (hwDone | hwError);
    // An engine pulse on the last watchdog cycle wins over the abort.
    assign wdFire   = busy & ~(hwDone | hwError) & (cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            ie      <= 1'b0;
            cfgQ    <= '0;
            cnt     <= '0;
            hwStart <= 1'b0;
            hwAbort <= 1'b0;
        end else begin
            hwStart <= accept;
            hwAbort <= wdFire;
            if (wrEn) begin
                cfgQ <= wrData[CFG_W+4:5];
                ie   <= wrData[4];
            end
            if (accept) begin
                busy <= 1'b1;
                cnt  <= '0;
            end else if (finish || wdFire) begin
                busy <= 1'b0;
            end else if (busy) begin
                cnt <= cnt + 1'b1;
            end
            // Hardware sets are OR'd in last so they beat the host W1C.
            done <= (done & ~(wrEn & wrData[2]) & ~accept) | (busy & hwDone);
            err  <= (err & ~(wrEn & wrData[3]) & ~accept) | (busy & hwError)
                  | (startReq & busy) | wdFire;
        end
    end

    assign regVal = {cfgQ, ie, err, done, busy, 1'b0};
endmodule

module csr_bank_ch #(
    parameter int CHANNELS = 4,
    parameter int CFG_W    = 8,
    parameter int TIMEOUT  = 1024
) (
    input  logic                      clock,
    input  logic                      reset_n,
    csr_bank_ch_if.slave              host,
    output logic [CHANNELS-1:0]       hw_start,
    input  logic [CHANNELS-1:0]       hw_done,
    input  logic [CHANNELS-1:0]       hw_error,
    output logic [CHANNELS-1:0]       hw_abort,
    output logic [CHANNELS*CFG_W-1:0] cfg,
    output logic                      irq
);
    localparam int REG_W = CFG_W + 5;

    logic [CHANNELS-1:0][REG_W-1:0] regVal;
    logic [CHANNELS-1:0]            irqVec;

    for (genvar c = 0; c < CHANNELS; c++) begin : gLane
        csr_bank_ch_lane #(.CFG_W(CFG_W), .TIMEOUT(TIMEOUT)) uLane (
            .clock   (clock),
            .reset_n (reset_n),
            .wrEn    (host.wr_en[c]),
            .wrData  (host.wr_data),
            .hwDone  (hw_done[c]),
            .hwError (hw_error[c]),
            .hwStart (hw_start[c]),
            .hwAbort (hw_abort[c]),
            .regVal  (regVal[c])
        );
        assign cfg[c*CFG_W +: CFG_W] = regVal[c][REG_W-1:5];
        assign irqVec[c] = (regVal[c][2] | regVal[c][3]) & regVal[c][4];
    end

    // Reads see pre-edge state; out-of-range selects return zero.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            host.rd_data  <= '0;
            host.rd_valid <= 1'b0;
            irq           <= 1'b0;
        end else begin
            host.rd_valid <= host.rd_en;
            irq           <= |irqVec;
            if (host.rd_en)
                host.rd_data <= (32'(host.rd_sel) < CHANNELS) ? regVal[host.rd_sel] : '0;
        end
    end
endmodule

// File: tb/tb_csr_bank_ch.sv
// Directed bench for csr_bank_ch (4 channels, CFG_W=8, TIMEOUT=16) plus a 3-channel copy for out-of-range reads.
module tb_csr_bank_ch;
    logic clock = 1'b0;
    logic reset_n;
    always #5 clock = ~clock;

    csr_bank_ch_if #(.CHANNELS(4), .CFG_W(8)) host ();
    logic [3:0]  hwStart, hwDone, hwError, hwAbort;
    logic [31:0] cfg;
    logic        irq;

    csr_bank_ch #(.CHANNELS(4), .CFG_W(8), .TIMEOUT(16)) uDut (
        .clock(clock), .reset_n(reset_n), .host(host.slave),
        .hw_start(hwStart), .hw_done(hwDone), .hw_error(hwError),
        .hw_abort(hwAbort), .cfg(cfg), .irq(irq)
    );

    csr_bank_ch_if #(.CHANNELS(3), .CFG_W(8)) host3 ();
    logic [2:0]  hwStart3, hwAbort3;
    logic [2:0]  hwZero3 = '0;
    logic [23:0] cfg3;
    logic        irq3;

    csr_bank_ch #(.CHANNELS(3), .CFG_W(8), .TIMEOUT(16)) uDut3 (
        .clock(clock), .reset_n(reset_n), .host(host3.slave),
        .hw_start(hwStart3), .hw_done(hwZero3), .hw_error(hwZero3),
        .hw_abort(hwAbort3), .cfg(cfg3), .irq(irq3)
    );

    int nChk = 0;
    int nBad = 0;
    logic [3:0] abortSeen;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nChk++;
        if (got !== exp) begin
            nBad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic wr(input logic [3:0] en, input logic [12:0] data);
        host.wr_en = en; host.wr_data = data;
        step();
        host.wr_en = '0; host.wr_data = '0;
    endtask

    task automatic rd(input int ch, input logic [12:0] exp, input string tag);
        host.rd_en = 1'b1; host.rd_sel = 2'(ch);
        step();
        host.rd_en = 1'b0;
        chk({tag, "_vld"}, 64'(host.rd_valid), 64'd1);
        chk(tag, 64'(host.rd_data), 64'(exp));
    endtask

    initial begin
        reset_n = 1'b0;
        host.wr_en = 4'($urandom); host.wr_data = 13'($urandom);
        host.rd_en = 1'b1; host.rd_sel = 2'($urandom);
        hwDone = 4'($urandom); hwError = 4'($urandom);
        host3.wr_en = '0; host3.wr_data = '0; host3.rd_en = 1'b0; host3.rd_sel = '0;
        repeat (3) step();
        chk("rst_outs", {host.rd_data, host.rd_valid, hwStart, hwAbort, cfg, irq}, 64'd0);
        host.wr_en = '0; host.wr_data = '0; host.rd_en = 1'b0; host.rd_sel = '0;
        hwDone = '0; hwError = '0;
        reset_n = 1'b1;
        for (int c = 0; c < 4; c++) rd(c, 13'h000, "rst_rd");

        // Basic run on ch1: cfg=0x2D, ie=1, start.
        wr(4'b0010, 13'h5B1);
        chk("basic_start", 64'(hwStart), 64'b0010);
        chk("basic_cfg", 64'(cfg[15:8]), 64'h2D);
        step();
        chk("basic_start_1cyc", 64'(hwStart), 64'd0);
        repeat (3) step();
        hwDone = 4'b0010; step(); hwDone = '0;
        chk("basic_irq_lat", 64'(irq), 64'd0);
        step();
        chk("basic_irq", 64'(irq), 64'd1);
        rd(1, 13'h5B4, "basic_done_rd");
        wr(4'b0010, 13'h5A4);
        step();
        chk("basic_irq_clr", 64'(irq), 64'd0);
        rd(1, 13'h5A0, "basic_w1c_rd");

        // Start while busy: error set, no second pulse.
        wr(4'b0010, 13'h5B1);
        chk("sb_start", 64'(hwStart), 64'b0010);
        wr(4'b0010, 13'h5B1);
        chk("sb_nostart", 64'(hwStart), 64'd0);
        rd(1, 13'h5BA, "sb_err_rd");
        hwDone = 4'b0010; step(); hwDone = '0;
        rd(1, 13'h5BC, "sb_done_rd");
        wr(4'b0010, 13'h00C);
        rd(1, 13'h000, "sb_clr_rd");

        // Watchdog on ch2: busy for exactly 16 cycles then abort.
        wr(4'b0100, 13'h001);
        chk("wd_start", 64'(hwStart), 64'b0100);
        abortSeen = '0;
        for (int i = 0; i < 15; i++) begin step(); abortSeen |= hwAbort; end
        chk("wd_early_abort", 64'(abortSeen), 64'd0);
        host.rd_en = 1'b1; host.rd_sel = 2'd2;
        step();
        chk("wd_abort", 64'(hwAbort), 64'b0100);
        chk("wd_busy_last", 64'(host.rd_data), 64'h002);
        step();
        host.rd_en = 1'b0;
        chk("wd_abort_1cyc", 64'(hwAbort), 64'd0);
        chk("wd_err", 64'(host.rd_data), 64'h008);

        // Done on the final watchdog cycle beats the abort.
        wr(4'b0100, 13'h001);
        abortSeen = '0;
        for (int i = 0; i < 15; i++) begin step(); abortSeen |= hwAbort; end
        hwDone = 4'b0100; step(); hwDone = '0;
        abortSeen |= hwAbort;
        step();
        abortSeen |= hwAbort;
        chk("wd_race_noabort", 64'(abortSeen), 64'd0);
        rd(2, 13'h004, "wd_race_rd");

        // Collision: hw_done vs host W1C of done, with a read on the same edge.
        wr(4'b0001, 13'h001);
        host.wr_en = 4'b0001; host.wr_data = 13'h004; hwDone = 4'b0001;
        host.rd_en = 1'b1; host.rd_sel = 2'd0;
        step();
        host.wr_en = '0; host.wr_data = '0; hwDone = '0; host.rd_en = 1'b0;
        chk("col_vld", 64'(host.rd_valid), 64'd1);
        chk("col_prewrite", 64'(host.rd_data), 64'h002);
        rd(0, 13'h004, "col_done_rd");
        step();
        chk("rd_vld_low", 64'(host.rd_valid), 64'd0);
        chk("rd_hold", 64'(host.rd_data), 64'h004);

        // All four channels started together.
        wr(4'b1111, 13'h001);
        chk("multi_start", 64'(hwStart), 64'b1111);
        step();
        chk("multi_start_1cyc", 64'(hwStart), 64'd0);
        hwDone = 4'b1111; step(); hwDone = '0;
        rd(3, 13'h004, "multi_rd3");
        chk("multi_irq_noie", 64'(irq), 64'd0);

        // Out-of-range select on a 3-channel bank.
        host3.wr_en = 3'b111; host3.wr_data = 13'hFE0;
        step();
        host3.wr_en = '0; host3.wr_data = '0;
        host3.rd_en = 1'b1; host3.rd_sel = 2'd2;
        step();
        chk("oor_inrange", 64'(host3.rd_data), 64'hFE0);
        host3.rd_sel = 2'd3;
        step();
        host3.rd_en = 1'b0;
        chk("oor_vld", 64'(host3.rd_valid), 64'd1);
        chk("oor_data", 64'(host3.rd_data), 64'd0);

        // Async reset mid-operation: outputs drop at once, no abort afterwards.
        wr(4'b1000, 13'h001);
        #2 reset_n = 1'b0;
        #1 chk("rst_mid_start", 64'(hwStart), 64'd0);
        step();
        reset_n = 1'b1;
        abortSeen = '0;
        for (int i = 0; i < 20; i++) begin step(); abortSeen |= hwAbort; end
        chk("rst_mid_noabort", 64'(abortSeen), 64'd0);
        rd(3, 13'h000, "rst_mid_rd");

        $display("test done: total=%0d bad=%0d", nChk, nBad);
        $finish;
    end
endmodule
